// File: rtl/coord_pkg.sv
// ----------------------------------------------------------------------------
// coord_pkg
// Shared definitions for the AHB rectangle-coordinate writer.
//   - Word offsets (HADDR[4:2]) of the register map
//   - AHB HTRANS encodings
//   - coord_t: one rectangle (x1, y1, x2, y2) as 16-bit shadow-width fields
// ----------------------------------------------------------------------------
package coord_pkg;

    localparam int SHADOW_W = 16;

    // Register map, word index = HADDR[4:2]
    localparam logic [2:0] OFF_X1     = 3'd0;
    localparam logic [2:0] OFF_Y1     = 3'd1;
    localparam logic [2:0] OFF_X2     = 3'd2;
    localparam logic [2:0] OFF_Y2     = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;
    localparam logic [2:0] OFF_FRAME  = 3'd6;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef struct packed {
        logic [SHADOW_W-1:0] x1;
        logic [SHADOW_W-1:0] y1;
        logic [SHADOW_W-1:0] x2;
        logic [SHADOW_W-1:0] y2;
    } coord_t;

endpackage

// File: rtl/coord_clamp_order.sv
// ----------------------------------------------------------------------------
// coord_clamp_order
// Purely combinational. Clamps each raw shadow coordinate to the visible area
// and orders each axis so that x1<=x2 and y1<=y2.
// Ports:
//   raw_i      - raw shadow rectangle (16-bit fields)
//   coord_o    - clamped and ordered rectangle
//   clamped_o  - 1 if any of the four raw values exceeded its limit
// ----------------------------------------------------------------------------
module coord_clamp_order
    import coord_pkg::*;
#(
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  coord_t raw_i,
    output coord_t coord_o,
    output logic   clamped_o
);

    localparam logic [SHADOW_W-1:0] XLIM = SHADOW_W'(X_MAX);
    localparam logic [SHADOW_W-1:0] YLIM = SHADOW_W'(Y_MAX);

    function automatic logic [SHADOW_W-1:0] clamp(input logic [SHADOW_W-1:0] v,
                                                  input logic [SHADOW_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    logic [SHADOW_W-1:0] cx1, cy1, cx2, cy2;

    assign cx1 = clamp(raw_i.x1, XLIM);
    assign cy1 = clamp(raw_i.y1, YLIM);
    assign cx2 = clamp(raw_i.x2, XLIM);
    assign cy2 = clamp(raw_i.y2, YLIM);

    assign clamped_o = (raw_i.x1 > XLIM) | (raw_i.x2 > XLIM) |
                       (raw_i.y1 > YLIM) | (raw_i.y2 > YLIM);

    // Ordering is done after clamping so the swap compares on-screen values.
    assign coord_o.x1 = (cx1 > cx2) ? cx2 : cx1;
    assign coord_o.x2 = (cx1 > cx2) ? cx1 : cx2;
    assign coord_o.y1 = (cy1 > cy2) ? cy2 : cy1;
    assign coord_o.y2 = (cy1 > cy2) ? cy1 : cy2;

endmodule

// File: rtl/ahb_coord_writer.sv
// ----------------------------------------------------------------------------
// ahb_coord_writer
// AHB-Lite slave holding shadow rectangle coordinates. A CPU commit request
// (CTRL bit0) is applied atomically on the next frame_start pulse, producing
// clamped, ordered (x1,y1,x2,y2) plus DataValid for the VGA drawing block.
// Ports:
//   HCLK, HRESET          - clock, asynchronous active-high reset
//   HSEL..HREADY, HWDATA  - AHB-Lite slave inputs (HSIZE ignored)
//   HRDATA                - read data, combinational in the data phase
//   HREADYOUT, HRESP      - constant 1 / OKAY (zero wait states)
//   frame_start           - one-cycle pulse at start of vertical blanking
//   x1, y1, x2, y2        - committed rectangle
//   DataValid             - high once any commit has happened
// ----------------------------------------------------------------------------
module ahb_coord_writer
    import coord_pkg::*;
#(
    parameter int X_W   = 10,
    parameter int Y_W   = 9,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  logic           HCLK,
    input  logic           HRESET,
    input  logic           HSEL,
    input  logic [31:0]    HADDR,
    input  logic [1:0]     HTRANS,
    input  logic           HWRITE,
    input  logic [2:0]     HSIZE,
    input  logic [31:0]    HWDATA,
    input  logic           HREADY,
    output logic [31:0]    HRDATA,
    output logic           HREADYOUT,
    output logic           HRESP,
    input  logic           frame_start,
    output logic [X_W-1:0] x1,
    output logic [Y_W-1:0] y1,
    output logic [X_W-1:0] x2,
    output logic [Y_W-1:0] y2,
    output logic           DataValid
);

    // Address-phase capture
    logic       dp_vld_q, dp_vld_d;
    logic       dp_wr_q, dp_wr_d;
    logic [2:0] dp_addr_q, dp_addr_d;

    // Register state
    coord_t              shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic                clamp_err_q, clamp_err_d;
    logic [SHADOW_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [X_W-1:0]      x1_q, x1_d, x2_q, x2_d;
    logic [Y_W-1:0]      y1_q, y1_d, y2_q, y2_d;
    logic                dv_q, dv_d;

    coord_t clamped;
    logic   clamp_hit;
    logic   wr_en;
    logic   commit;

    coord_clamp_order #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_clamp (
        .raw_i     (shadow_q),
        .coord_o   (clamped),
        .clamped_o (clamp_hit)
    );

    assign wr_en  = dp_vld_q & dp_wr_q;
    assign commit = frame_start & pending_q;

    always_comb begin
        dp_vld_d    = HSEL & HREADY & HTRANS[1];
        dp_wr_d     = HWRITE;
        dp_addr_d   = HADDR[4:2];

        shadow_d    = shadow_q;
        pending_d   = pending_q;
        clamp_err_d = clamp_err_q;
        frame_cnt_d = frame_cnt_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        x2_d        = x2_q;
        y2_d        = y2_q;
        dv_d        = dv_q;

        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        // Commit reads shadow_q, so a same-cycle shadow write lands after it.
        if (commit) begin
            x1_d      = clamped.x1[X_W-1:0];
            y1_d      = clamped.y1[Y_W-1:0];
            x2_d      = clamped.x2[X_W-1:0];
            y2_d      = clamped.y2[Y_W-1:0];
            dv_d      = 1'b1;
            pending_d = 1'b0;
        end

        // Bus writes follow the commit so a CTRL write re-arms pending.
        if (wr_en) begin
            unique case (dp_addr_q)
                OFF_X1:     shadow_d.x1 = HWDATA[SHADOW_W-1:0];
                OFF_Y1:     shadow_d.y1 = HWDATA[SHADOW_W-1:0];
                OFF_X2:     shadow_d.x2 = HWDATA[SHADOW_W-1:0];
                OFF_Y2:     shadow_d.y2 = HWDATA[SHADOW_W-1:0];
                OFF_CTRL:   if (HWDATA[0]) pending_d = 1'b1;
                OFF_STATUS: if (HWDATA[1]) clamp_err_d = 1'b0;
                default:    ;
            endcase
        end

        // A clamp event beats a simultaneous software clear.
        if (commit && clamp_hit) begin
            clamp_err_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_vld_q    <= 1'b0;
            dp_wr_q     <= 1'b0;
            dp_addr_q   <= 3'd0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            clamp_err_q <= 1'b0;
            frame_cnt_q <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            dv_q        <= 1'b0;
        end else begin
            dp_vld_q    <= dp_vld_d;
            dp_wr_q     <= dp_wr_d;
            dp_addr_q   <= dp_addr_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            clamp_err_q <= clamp_err_d;
            frame_cnt_q <= frame_cnt_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            x2_q        <= x2_d;
            y2_q        <= y2_d;
            dv_q        <= dv_d;
        end
    end

    // Data-phase read mux
    always_comb begin
        HRDATA = 32'd0;
        if (dp_vld_q && !dp_wr_q) begin
            unique case (dp_addr_q)
                OFF_X1:     HRDATA = {16'd0, shadow_q.x1};
                OFF_Y1:     HRDATA = {16'd0, shadow_q.y1};
                OFF_X2:     HRDATA = {16'd0, shadow_q.x2};
                OFF_Y2:     HRDATA = {16'd0, shadow_q.y2};
                OFF_STATUS: HRDATA = {30'd0, clamp_err_q, pending_q};
                OFF_FRAME:  HRDATA = {16'd0, frame_cnt_q};
                default:    HRDATA = 32'd0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign x1        = x1_q;
    assign y1        = y1_q;
    assign x2        = x2_q;
    assign y2        = y2_q;
    assign DataValid = dv_q;

    // Bits the design intentionally does not look at.
    logic unused_ok;
    assign unused_ok = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:16],
                         clamped.x1[SHADOW_W-1:X_W], clamped.x2[SHADOW_W-1:X_W],
                         clamped.y1[SHADOW_W-1:Y_W], clamped.y2[SHADOW_W-1:Y_W]};

endmodule

// File: tb/tb_ahb_coord_writer.sv
// ----------------------------------------------------------------------------
// tb_ahb_coord_writer
// Scoreboard bench: the driver keeps a behavioural model of the register file
// and rectangle, pushes expected read data / committed outputs into queues,
// and a monitor compares them when the DUT presents them.
// ----------------------------------------------------------------------------
module tb_ahb_coord_writer;

    localparam int X_MAX = 639;
    localparam int Y_MAX = 479;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = 32'd0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = 32'd0;
    logic        HREADY = 1'b1;
    logic        frame_start = 1'b0;
    logic [31:0] HRDATA;
    logic        HREADYOUT, HRESP, DataValid;
    logic [9:0]  x1, x2;
    logic [8:0]  y1, y2;

    ahb_coord_writer dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .frame_start(frame_start), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .DataValid(DataValid)
    );

    always #5 HCLK = ~HCLK;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    typedef struct {
        bit          vld;
        bit          wr;
        logic [2:0]  a;
        logic [31:0] d;
    } op_t;

    typedef struct {
        int unsigned x1, y1, x2, y2;
        bit          dv;
    } out_t;

    // Reference model: registers indexed by word offset, rectangle as ints.
    int unsigned m_sh[4];
    int unsigned m_out[4];
    bit          m_pend, m_cerr, m_dv;
    int unsigned m_fcnt;

    logic [31:0] rdq[$];
    int unsigned rda[$];
    out_t        outq[$];
    op_t         prev;

    function automatic op_t mk(bit vld, bit wr, logic [2:0] a, logic [31:0] d);
        op_t o;
        o.vld = vld; o.wr = wr; o.a = a; o.d = d;
        return o;
    endfunction

    function automatic int unsigned lim(int unsigned v, int unsigned m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic [31:0] model_read(logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3: return m_sh[a];
            3'd5:                   return {30'd0, m_cerr, m_pend};
            3'd6:                   return m_fcnt;
            default:                return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_out[i] = 0; end
        m_pend = 0; m_cerr = 0; m_dv = 0; m_fcnt = 0;
    endtask

    // One clock edge: frame_start effects and the write whose data phase ends here.
    task automatic model_edge(input op_t p, input bit fs);
        bit          commit;
        bit          hit;
        int unsigned c[4];
        commit = fs && m_pend;
        hit = 0;
        if (fs) m_fcnt = (m_fcnt + 1) % 65536;
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                int unsigned mx;
                mx = (i % 2 == 0) ? X_MAX : Y_MAX;
                c[i] = lim(m_sh[i], mx);
                if (m_sh[i] > mx) hit = 1;
            end
            m_out[0] = (c[0] < c[2]) ? c[0] : c[2];
            m_out[2] = (c[0] < c[2]) ? c[2] : c[0];
            m_out[1] = (c[1] < c[3]) ? c[1] : c[3];
            m_out[3] = (c[1] < c[3]) ? c[3] : c[1];
            m_pend = 0;
            m_dv = 1;
        end
        if (p.vld && p.wr) begin
            case (p.a)
                3'd0, 3'd1, 3'd2, 3'd3: m_sh[p.a] = p.d[15:0];
                3'd4: if (p.d[0]) m_pend = 1;
                3'd5: if (p.d[1]) m_cerr = 0;
                default: ;
            endcase
        end
        if (commit && hit) m_cerr = 1;
    endtask

    // Called #1 after a rising edge: drives the next address phase and the
    // previous transfer's data phase, then advances one clock.
    task automatic cycle(input op_t op, input bit fs);
        out_t o;
        if (prev.vld && !prev.wr) begin
            rdq.push_back(model_read(prev.a));
            rda.push_back(prev.a);
        end
        HSEL   = op.vld;
        HTRANS = op.vld ? 2'b10 : 2'b00;
        HWRITE = op.wr;
        HADDR  = $urandom();
        HADDR[4:2] = op.a;
        HWDATA = (prev.vld && prev.wr) ? prev.d : $urandom();
        frame_start = fs;
        model_edge(prev, fs);
        if (fs) begin
            o.x1 = m_out[0]; o.y1 = m_out[1]; o.x2 = m_out[2]; o.y2 = m_out[3];
            o.dv = m_dv;
            outq.push_back(o);
        end
        prev = op;
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d); cycle(mk(1, 1, a, d), 0); endtask
    task automatic rd(input logic [2:0] a);                      cycle(mk(1, 0, a, 0), 0); endtask
    task automatic idle(input int n, input bit fs);
        for (int i = 0; i < n; i++) cycle(mk(0, 0, 0, 0), fs);
    endtask

    task automatic check_outs_direct(input string tag);
        check({tag, "_x1"}, x1, m_out[0]);
        check({tag, "_y1"}, y1, m_out[1]);
        check({tag, "_x2"}, x2, m_out[2]);
        check({tag, "_y2"}, y2, m_out[3]);
        check({tag, "_dv"}, DataValid, m_dv);
    endtask

    // Monitor
    bit rd_dp, fs_seen;
    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rd_dp   <= 1'b0;
            fs_seen <= 1'b0;
        end else begin
            rd_dp   <= HSEL && HREADY && HTRANS[1] && !HWRITE;
            fs_seen <= frame_start;
        end
    end

    always @(negedge HCLK) begin
        if (!HRESET) begin
            if (rd_dp) begin
                if (rdq.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    logic [31:0] e;
                    int unsigned a;
                    e = rdq.pop_front();
                    a = rda.pop_front();
                    check($sformatf("hrdata_off%0d", a * 4), HRDATA, e);
                    check("hreadyout", HREADYOUT, 1);
                    check("hresp", HRESP, 0);
                end
            end
            if (fs_seen) begin
                if (outq.size() == 0) begin
                    check("out_unexpected", 1, 0);
                end else begin
                    out_t e;
                    e = outq.pop_front();
                    check("out_x1", x1, e.x1);
                    check("out_y1", y1, e.y1);
                    check("out_x2", x2, e.x2);
                    check("out_y2", y2, e.y2);
                    check("out_dv", DataValid, e.dv);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return $urandom_range(0, 700);
            2:       return $urandom_range(400, 1000);
            default: return $urandom_range(0, 3);
        endcase
    endfunction

    initial begin
        model_reset();
        prev = mk(0, 0, 0, 0);

        // Reset state
        #3;
        check_outs_direct("rst");
        check("rst_hrdata", HRDATA, 0);
        check("rst_hreadyout", HREADYOUT, 1);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        for (int a = 0; a < 8; a++) rd(3'(a));
        idle(1, 0);

        // Basic commit
        wr(0, 100); wr(1, 50); wr(2, 300); wr(3, 200); wr(4, 1);
        idle(1, 1);
        rd(5); rd(6); rd(0);

        // Clamp and swap, then sticky-error clear
        wr(0, 700); wr(2, 20); wr(1, 500); wr(3, 10); wr(4, 1);
        idle(1, 1);
        rd(5); wr(5, 2); rd(5);

        // Shadow write coincident with commit
        wr(0, 100); wr(4, 1); wr(0, 5);
        idle(1, 1);
        rd(0); rd(5);

        // CTRL write coincident with commit
        wr(4, 1); wr(4, 1);
        idle(1, 1);
        rd(5);
        idle(1, 1);
        rd(5);

        // STATUS clear coincident with a clamping commit
        wr(0, 900); wr(4, 1); wr(5, 2);
        idle(1, 1);
        rd(5);
        idle(1, 0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            op_t o;
            bit  fs;
            o = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   3'($urandom_range(0, 7)), rnd_data());
            if (o.a == 3'd4 && $urandom_range(0, 1) == 1) o.d[0] = 1'b1;
            fs = ($urandom_range(0, 5) == 0);
            cycle(o, fs);
        end
        idle(2, 0);

        // Frame counter wrap from reset
        HRESET = 1'b1;
        HSEL = 0; HTRANS = 2'b00; frame_start = 0;
        rdq.delete(); rda.delete(); outq.delete();
        model_reset();
        prev = mk(0, 0, 0, 0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        idle(65536, 1);
        rd(6);
        idle(1, 0);

        // Reset during the data phase of an X2 write
        wr(0, 10); wr(2, 400); wr(4, 1);
        idle(1, 1);
        wr(2, 123);
        HWDATA = 32'd123;
        HRESET = 1'b1;
        HSEL = 0; HTRANS = 2'b00; frame_start = 0;
        rdq.delete(); rda.delete(); outq.delete();
        model_reset();
        prev = mk(0, 0, 0, 0);
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        check_outs_direct("midrst");
        rd(2); rd(5); rd(6);
        idle(3, 0);

        check("rdq_drained", rdq.size(), 0);
        check("outq_drained", outq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
